pcs_rx_sync_param: RTL and testbench
====================================

// Module: pcs_rx_sync_param
// PURPOSE
//  Parametrised 1000BASE-X code-group synchronisation FSM (IEEE 802.3 cl.36 fig 36-9), generalised.
//  Sits between the 10b deserialiser/8b10b decoder and the rx FSM in the receive path.
//  Drives code_sync_status and rx_even.
//  Adds over the fixed sync block:
//   - programmable acquire/loss/recover thresholds
//   - code-group enable
//   - bad-level visibility
//   - saturating loss-of-sync event counter
// PARAMETERS
//  COMMA_ACQ   3   commas (each followed by /D/) needed to reach sync; 1..7
//  BAD_LIMIT   4   consecutive bad levels; cgbad at level BAD_LIMIT-1 -> loss; 2..8
//  GOOD_RECOV  3   consecutive good code-groups to decrement bad level by one; 1..15
//  CNT_W       8   width of loss-of-sync event counter
// PORTS
//  clk            in   1      receive clock
//  reset          in   1      asynchronous, active-low reset
//  signal_detect  in   1      PMD signal detect; 0 forces LOSS
//  cg_en          in   1      1 = cg_in/flags carry a new code-group this cycle
//  cg_in          in   10     code-group; cg_in[9] = bit 'a' (first on wire)
//  cg_invalid     in   1      decoder: code-group invalid for current running disparity
//  cg_is_k        in   1      decoder: valid special (K) code-group
//  cg_out         out  10     cg_in registered on cg_en
//  comma_out      out  1      registered comma flag, aligned with cg_out
//  code_sync_status out 1     1 while in SYNC
//  rx_even        out  1      even/odd code-group marker, aligned with cg_out
//  bad_level      out  3      current bad level (0 outside SYNC)
//  loss_cnt       out  CNT_W  SYNC->LOSS event count, saturating
//  loss_cnt_clr   in   1      synchronous clear of loss_cnt
// BEHAVIOUR
//  Reset values (reset=0, async)
//   - state=LOSS; cg_out=0; comma_out=0; code_sync_status=0; rx_even=0; bad_level=0; loss_cnt=0
//   - internal comma_cnt and good_cnt = 0
//  Code-group classification
//   - comma = cg_in[9:3] is 7'b0011111 or 7'b1100000
//   - data (/D/) = !cg_invalid & !cg_is_k
//   - cgbad = cg_invalid | (comma & rx_even==1), where rx_even is the pre-update register value
//   - cggood = !cgbad
//  Update timing
//   - FSM, rx_even and cg_out update only on cycles with cg_en=1; otherwise hold
//   - Latency 1 clk: outputs describe the code-group accepted on the previous enabled edge
//  signal_detect=0 overrides everything
//   - next edge: state=LOSS, counters cleared, code_sync_status=0, regardless of cg_en
//  States (updates listed are per enabled cycle)
//   - LOSS: rx_even toggles. comma & signal_detect -> COMMA_DET, comma_cnt=1, rx_even=1.
//   - COMMA_DET: on /D/, rx_even=0.
//       comma_cnt==COMMA_ACQ -> SYNC, level 0, code_sync_status=1.
//       Otherwise -> ACQ.
//     Any non-/D/ -> LOSS.
//   - ACQ: rx_even toggles.
//       cgbad -> LOSS.
//       comma & rx_even==0 -> COMMA_DET, comma_cnt+1, rx_even=1.
//       Else stay.
//   - SYNC: rx_even toggles; code_sync_status=1.
//       cgbad: level==BAD_LIMIT-1 -> LOSS, code_sync_status=0, loss_cnt+1.
//              Otherwise level+1, good_cnt=0.
//       cggood & level>0: good_cnt+1. On reaching GOOD_RECOV: level-1, good_cnt=0.
//       cggood & level==0: no change.
//  loss_cnt
//   - Saturates at all-ones
//   - loss_cnt_clr wins over a same-cycle increment (that event is dropped)
//  Mid-operation reset: async return to reset values; first code-group after release is evaluated in LOSS.
// TESTING
//  1. Reset, signal_detect=1, K28.5/D16.2 pairs x3 -> code_sync_status=1 one clk after 3rd D16.2; rx_even=1 on each K28.5.
//  2. In SYNC, 4 consecutive invalid cgs (defaults) -> bad_level 1,2,3, then status=0 and loss_cnt 0->1.
//  3. In SYNC, 2 invalid, then 3 good -> bad_level 2->1; 3 more good -> 0; status stays 1.
//  4. K28.5 arriving with rx_even=1 while in ACQ -> LOSS; sync not declared.
//  5. signal_detect dropped for 1 clk mid-SYNC with cg_en=0 -> status=0 next edge, bad_level=0.
//  6. CNT_W=2: 5 loss events -> loss_cnt=3 (saturated); loss_cnt_clr with simultaneous event -> 0.

Source files
------------

// File: rtl/pcs_rx_sync_param.sv
// -----------------------------------------------------------------------------
// pcs_rx_sync_param
// 1000BASE-X code-group synchronisation state machine with programmable
// acquire / loss / recovery thresholds.
//
// Sits after the deserialiser and 8b10b decoder. It tracks comma alignment,
// declares code_sync_status and marks even/odd code-groups for the rx FSM.
//
// Parameters
//   COMMA_ACQ   commas (each followed by /D/) needed to reach sync, 1..7
//   BAD_LIMIT   bad levels; a cgbad at level BAD_LIMIT-1 drops sync, 2..8
//   GOOD_RECOV  consecutive good code-groups that lower the bad level, 1..15
//   CNT_W       width of the saturating loss-of-sync event counter
//
// Ports
//   clk              receive clock
//   reset            asynchronous active-low reset
//   signal_detect    PMD signal detect, 0 forces loss of sync
//   cg_en            cg_in and decoder flags carry a new code-group
//   cg_in[9:0]       code-group, cg_in[9] is bit 'a' (first on the wire)
//   cg_invalid       decoder: invalid for the current running disparity
//   cg_is_k          decoder: valid special (K) code-group
//   loss_cnt_clr     synchronous clear of loss_cnt
//   cg_out[9:0]      cg_in registered on cg_en
//   comma_out        comma flag aligned with cg_out
//   code_sync_status 1 while synchronised
//   rx_even          even/odd marker aligned with cg_out
//   bad_level[2:0]   current bad level (0 outside sync)
//   loss_cnt         sync-to-loss event count, saturating
// -----------------------------------------------------------------------------
module pcs_rx_sync_param #(
  parameter int COMMA_ACQ  = 3,
  parameter int BAD_LIMIT  = 4,
  parameter int GOOD_RECOV = 3,
  parameter int CNT_W      = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             signal_detect,
  input  logic             cg_en,
  input  logic [9:0]       cg_in,
  input  logic             cg_invalid,
  input  logic             cg_is_k,
  input  logic             loss_cnt_clr,
  output logic [9:0]       cg_out,
  output logic             comma_out,
  output logic             code_sync_status,
  output logic             rx_even,
  output logic [2:0]       bad_level,
  output logic [CNT_W-1:0] loss_cnt
);

  typedef enum logic [1:0] {
    ST_LOSS      = 2'd0,
    ST_COMMA_DET = 2'd1,
    ST_ACQ       = 2'd2,
    ST_SYNC      = 2'd3
  } state_t;

  localparam logic [2:0]       ACQ_TGT  = 3'(COMMA_ACQ);
  localparam logic [2:0]       BAD_TOP  = 3'(BAD_LIMIT - 1);
  localparam logic [3:0]       GOOD_TGT = 4'(GOOD_RECOV);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  // Comma = the 7-bit comma pattern in either disparity.
  function automatic logic is_comma(input logic [9:0] cg);
    is_comma = (cg[9:3] == 7'b0011111) || (cg[9:3] == 7'b1100000);
  endfunction

  state_t           state_r, state_s;
  logic [2:0]       comma_cnt_r, comma_cnt_s;
  logic [3:0]       good_cnt_r, good_cnt_s;
  logic [2:0]       bad_level_r, bad_level_s;
  logic             rx_even_r, rx_even_s;
  logic [9:0]       cg_out_r;
  logic             comma_out_r;
  logic             status_r;
  logic [CNT_W-1:0] loss_cnt_r, loss_cnt_s;
  logic             loss_event_s;

  logic comma_s, data_s, cgbad_s;

  // Classification of the incoming code-group against the current parity.
  always_comb begin
    comma_s = is_comma(cg_in);
    data_s  = !cg_invalid && !cg_is_k;
    cgbad_s = cg_invalid || (comma_s && rx_even_r);
  end

  // Next-state and counter updates; only enabled cycles advance the FSM.
  always_comb begin
    state_s      = state_r;
    comma_cnt_s  = comma_cnt_r;
    good_cnt_s   = good_cnt_r;
    bad_level_s  = bad_level_r;
    rx_even_s    = rx_even_r;
    loss_event_s = 1'b0;
    if (!signal_detect) begin
      // Loss of signal: behave as LOSS with everything cleared.
      state_s     = ST_LOSS;
      comma_cnt_s = 3'd0;
      good_cnt_s  = 4'd0;
      bad_level_s = 3'd0;
      if (cg_en) begin
        rx_even_s = !rx_even_r;
      end else begin
        rx_even_s = rx_even_r;
      end
    end else if (cg_en) begin
      case (state_r)
        ST_LOSS: begin
          if (comma_s) begin
            state_s     = ST_COMMA_DET;
            comma_cnt_s = 3'd1;
            rx_even_s   = 1'b1;
          end else begin
            rx_even_s = !rx_even_r;
          end
        end
        ST_COMMA_DET: begin
          if (data_s) begin
            rx_even_s = 1'b0;
            if (comma_cnt_r == ACQ_TGT) begin
              state_s     = ST_SYNC;
              bad_level_s = 3'd0;
              good_cnt_s  = 4'd0;
            end else begin
              state_s = ST_ACQ;
            end
          end else begin
            state_s     = ST_LOSS;
            comma_cnt_s = 3'd0;
            rx_even_s   = !rx_even_r;
          end
        end
        ST_ACQ: begin
          if (cgbad_s) begin
            state_s     = ST_LOSS;
            comma_cnt_s = 3'd0;
            rx_even_s   = !rx_even_r;
          end else if (comma_s) begin
            // A good comma here is necessarily on an even position.
            state_s     = ST_COMMA_DET;
            comma_cnt_s = comma_cnt_r + 3'd1;
            rx_even_s   = 1'b1;
          end else begin
            rx_even_s = !rx_even_r;
          end
        end
        ST_SYNC: begin
          rx_even_s = !rx_even_r;
          if (cgbad_s) begin
            if (bad_level_r == BAD_TOP) begin
              state_s      = ST_LOSS;
              bad_level_s  = 3'd0;
              good_cnt_s   = 4'd0;
              comma_cnt_s  = 3'd0;
              loss_event_s = 1'b1;
            end else begin
              bad_level_s = bad_level_r + 3'd1;
              good_cnt_s  = 4'd0;
            end
          end else if (bad_level_r != 3'd0) begin
            if ((good_cnt_r + 4'd1) == GOOD_TGT) begin
              bad_level_s = bad_level_r - 3'd1;
              good_cnt_s  = 4'd0;
            end else begin
              good_cnt_s = good_cnt_r + 4'd1;
            end
          end else begin
            good_cnt_s = good_cnt_r;
          end
        end
        default: begin
          state_s     = ST_LOSS;
          comma_cnt_s = 3'd0;
          good_cnt_s  = 4'd0;
          bad_level_s = 3'd0;
        end
      endcase
    end else begin
      state_s = state_r;
    end
  end

  // Loss counter: clear beats a same-cycle event; saturates at all-ones.
  always_comb begin
    loss_cnt_s = loss_cnt_r;
    if (loss_cnt_clr) begin
      loss_cnt_s = '0;
    end else if (loss_event_s && (loss_cnt_r != CNT_MAX)) begin
      loss_cnt_s = loss_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      loss_cnt_s = loss_cnt_r;
    end
  end

  // State and control registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r     <= ST_LOSS;
      comma_cnt_r <= 3'd0;
      good_cnt_r  <= 4'd0;
      bad_level_r <= 3'd0;
      rx_even_r   <= 1'b0;
      status_r    <= 1'b0;
      loss_cnt_r  <= '0;
    end else begin
      state_r     <= state_s;
      comma_cnt_r <= comma_cnt_s;
      good_cnt_r  <= good_cnt_s;
      bad_level_r <= bad_level_s;
      rx_even_r   <= rx_even_s;
      status_r    <= (state_s == ST_SYNC);
      loss_cnt_r  <= loss_cnt_s;
    end
  end

  // Code-group pass-through, aligned with rx_even.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cg_out_r    <= 10'd0;
      comma_out_r <= 1'b0;
    end else if (cg_en) begin
      cg_out_r    <= cg_in;
      comma_out_r <= comma_s;
    end else begin
      cg_out_r    <= cg_out_r;
      comma_out_r <= comma_out_r;
    end
  end

  assign cg_out           = cg_out_r;
  assign comma_out        = comma_out_r;
  assign code_sync_status = status_r;
  assign rx_even          = rx_even_r;
  assign bad_level        = bad_level_r;
  assign loss_cnt         = loss_cnt_r;

endmodule

// File: tb/tb_pcs_rx_sync_param.sv
// -----------------------------------------------------------------------------
// Bench for pcs_rx_sync_param: directed scenarios plus a randomized stream
// compared against a behavioural model. Two instances share the stimulus: one
// with default parameters, one with a 2-bit loss counter.
// -----------------------------------------------------------------------------
module tb_pcs_rx_sync_param;

  localparam int P_ACQ  = 3;
  localparam int P_BAD  = 4;
  localparam int P_GOOD = 3;

  localparam logic [9:0] K285N = 10'b0011111010;
  localparam logic [9:0] K285P = 10'b1100000101;
  localparam logic [9:0] D162  = 10'b0110110101;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       signal_detect = 1'b1;
  logic       cg_en = 1'b0;
  logic [9:0] cg_in = 10'd0;
  logic       cg_invalid = 1'b0;
  logic       cg_is_k = 1'b0;
  logic       loss_cnt_clr = 1'b0;

  logic [9:0] cg_out, cg_out2;
  logic       comma_out, comma_out2;
  logic       code_sync_status, code_sync_status2;
  logic       rx_even, rx_even2;
  logic [2:0] bad_level, bad_level2;
  logic [7:0] loss_cnt;
  logic [1:0] loss_cnt2;

  int n_checks = 0;
  int n_fail   = 0;

  pcs_rx_sync_param u_dut (
    .clk(clk), .reset(reset), .signal_detect(signal_detect), .cg_en(cg_en),
    .cg_in(cg_in), .cg_invalid(cg_invalid), .cg_is_k(cg_is_k),
    .loss_cnt_clr(loss_cnt_clr), .cg_out(cg_out), .comma_out(comma_out),
    .code_sync_status(code_sync_status), .rx_even(rx_even),
    .bad_level(bad_level), .loss_cnt(loss_cnt)
  );

  pcs_rx_sync_param #(.CNT_W(2)) u_dut2 (
    .clk(clk), .reset(reset), .signal_detect(signal_detect), .cg_en(cg_en),
    .cg_in(cg_in), .cg_invalid(cg_invalid), .cg_is_k(cg_is_k),
    .loss_cnt_clr(loss_cnt_clr), .cg_out(cg_out2), .comma_out(comma_out2),
    .code_sync_status(code_sync_status2), .rx_even(rx_even2),
    .bad_level(bad_level2), .loss_cnt(loss_cnt2)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  // phase: 0 loss, 1 just saw comma, 2 acquiring, 3 synchronised
  int         m_phase;
  int         m_commas;
  int         m_goods;
  int         m_level;
  bit         m_even;
  logic [9:0] m_cg;
  bit         m_comma;
  int         m_loss;
  int         m_loss2;

  task automatic model_reset();
    m_phase = 0; m_commas = 0; m_goods = 0; m_level = 0; m_even = 0;
    m_cg = 10'd0; m_comma = 0; m_loss = 0; m_loss2 = 0;
  endtask

  task automatic model_step(input bit sd, input bit en, input logic [9:0] cg,
                            input bit inv, input bit k, input bit clr);
    bit comma, dat, bad, ev;
    comma = (cg[9:3] == 7'b0011111) || (cg[9:3] == 7'b1100000);
    dat   = !inv && !k;
    bad   = inv || (comma && m_even);
    ev    = 0;
    if (!sd) begin
      m_phase = 0; m_commas = 0; m_goods = 0; m_level = 0;
      if (en) m_even = !m_even;
    end else if (en) begin
      if (m_phase == 0) begin
        if (comma) begin m_phase = 1; m_commas = 1; m_even = 1; end
        else m_even = !m_even;
      end else if (m_phase == 1) begin
        if (dat) begin
          m_even = 0;
          m_phase = (m_commas == P_ACQ) ? 3 : 2;
          m_level = 0; m_goods = 0;
        end else begin
          m_phase = 0; m_commas = 0; m_even = !m_even;
        end
      end else if (m_phase == 2) begin
        if (bad) begin m_phase = 0; m_commas = 0; m_even = !m_even; end
        else if (comma) begin m_phase = 1; m_commas++; m_even = 1; end
        else m_even = !m_even;
      end else begin
        m_even = !m_even;
        if (bad) begin
          if (m_level == P_BAD - 1) begin
            m_phase = 0; m_level = 0; m_goods = 0; m_commas = 0; ev = 1;
          end else begin
            m_level++; m_goods = 0;
          end
        end else if (m_level > 0) begin
          m_goods++;
          if (m_goods == P_GOOD) begin m_level--; m_goods = 0; end
        end
      end
    end
    if (en) begin m_cg = cg; m_comma = comma; end
    if (clr) begin m_loss = 0; m_loss2 = 0; end
    else if (ev) begin
      m_loss  = (m_loss  < 255) ? m_loss + 1  : 255;
      m_loss2 = (m_loss2 < 3)   ? m_loss2 + 1 : 3;
    end
  endtask

  // Apply one cycle of stimulus, advance the model, settle past the edge.
  task automatic drive(input bit sd, input bit en, input logic [9:0] cg,
                       input bit inv, input bit k, input bit clr);
    signal_detect = sd; cg_en = en; cg_in = cg;
    cg_invalid = inv; cg_is_k = k; loss_cnt_clr = clr;
    model_step(sd, en, cg, inv, k, clr);
    @(posedge clk);
    #1;
  endtask

  task automatic sync_up();
    for (int i = 0; i < P_ACQ; i++) begin
      drive(1, 1, K285N, 0, 1, 0);
      drive(1, 1, D162, 0, 0, 0);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b0;
    #3;
    model_reset();
    n_checks++;
    if (cg_out !== 10'd0 || comma_out !== 1'b0 || code_sync_status !== 1'b0 ||
        rx_even !== 1'b0 || bad_level !== 3'd0 || loss_cnt !== 8'd0 || loss_cnt2 !== 2'd0) begin
      n_fail++;
      $display("FAIL reset: cg=%h comma=%b st=%b even=%b lvl=%0d loss=%0d loss2=%0d required all zero",
               cg_out, comma_out, code_sync_status, rx_even, bad_level, loss_cnt, loss_cnt2);
    end
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_acquire();
    for (int i = 0; i < P_ACQ; i++) begin
      drive(1, 1, K285N, 0, 1, 0);
      n_checks++;
      if (rx_even !== 1'b1 || comma_out !== 1'b1 || cg_out !== K285N) begin
        n_fail++;
        $display("FAIL acq_comma%0d: even=%b comma=%b cg=%h required 1 1 %h", i, rx_even, comma_out, cg_out, K285N);
      end
      n_checks++;
      if (code_sync_status !== 1'b0) begin
        n_fail++;
        $display("FAIL acq_early%0d: status=%b required 0", i, code_sync_status);
      end
      drive(1, 1, D162, 0, 0, 0);
      n_checks++;
      if (rx_even !== 1'b0 || code_sync_status !== (i == P_ACQ - 1)) begin
        n_fail++;
        $display("FAIL acq_data%0d: even=%b status=%b required 0 %b", i, rx_even, code_sync_status, (i == P_ACQ - 1));
      end
    end
  endtask

  task automatic test_loss_bad();
    for (int i = 1; i <= P_BAD; i++) begin
      drive(1, 1, D162, 1, 0, 0);
      n_checks++;
      if (i < P_BAD) begin
        if (bad_level !== 3'(i) || code_sync_status !== 1'b1 || loss_cnt !== 8'd0) begin
          n_fail++;
          $display("FAIL loss_bad%0d: lvl=%0d st=%b loss=%0d required %0d 1 0", i, bad_level, code_sync_status, loss_cnt, i);
        end
      end else begin
        if (bad_level !== 3'd0 || code_sync_status !== 1'b0 || loss_cnt !== 8'd1) begin
          n_fail++;
          $display("FAIL loss_final: lvl=%0d st=%b loss=%0d required 0 0 1", bad_level, code_sync_status, loss_cnt);
        end
      end
    end
  endtask

  task automatic test_recover();
    int exp_lvl[6] = '{2, 2, 1, 1, 1, 0};
    sync_up();
    drive(1, 1, D162, 1, 0, 0);
    drive(1, 1, D162, 1, 0, 0);
    n_checks++;
    if (bad_level !== 3'd2) begin
      n_fail++;
      $display("FAIL recov_start: lvl=%0d required 2", bad_level);
    end
    for (int i = 0; i < 6; i++) begin
      drive(1, 1, D162, 0, 0, 0);
      n_checks++;
      if (bad_level !== 3'(exp_lvl[i]) || code_sync_status !== 1'b1) begin
        n_fail++;
        $display("FAIL recov%0d: lvl=%0d st=%b required %0d 1", i, bad_level, code_sync_status, exp_lvl[i]);
      end
    end
  endtask

  task automatic test_acq_misaligned();
    drive(0, 0, D162, 0, 0, 0);
    drive(1, 1, K285N, 0, 1, 0);
    drive(1, 1, D162, 0, 0, 0);
    drive(1, 1, D162, 0, 0, 0);
    drive(1, 1, K285P, 0, 1, 0);
    n_checks++;
    if (code_sync_status !== 1'b0 || rx_even !== 1'b0) begin
      n_fail++;
      $display("FAIL misalign_k: st=%b even=%b required 0 0", code_sync_status, rx_even);
    end
    // If the odd comma had been accepted, these would complete acquisition.
    drive(1, 1, D162, 0, 0, 0);
    drive(1, 1, K285N, 0, 1, 0);
    drive(1, 1, D162, 0, 0, 0);
    drive(1, 1, K285N, 0, 1, 0);
    drive(1, 1, D162, 0, 0, 0);
    n_checks++;
    if (code_sync_status !== 1'b0) begin
      n_fail++;
      $display("FAIL misalign_nosync: st=%b required 0", code_sync_status);
    end
  endtask

  task automatic test_signal_detect();
    logic       even_hold;
    logic [9:0] cg_hold;
    sync_up();
    drive(1, 1, D162, 1, 0, 0);
    even_hold = m_even;
    cg_hold   = m_cg;
    n_checks++;
    if (bad_level !== 3'd1 || code_sync_status !== 1'b1) begin
      n_fail++;
      $display("FAIL sd_pre: lvl=%0d st=%b required 1 1", bad_level, code_sync_status);
    end
    drive(0, 0, K285N, 0, 1, 0);
    n_checks++;
    if (code_sync_status !== 1'b0 || bad_level !== 3'd0 || rx_even !== even_hold || cg_out !== cg_hold) begin
      n_fail++;
      $display("FAIL sd_drop: st=%b lvl=%0d even=%b cg=%h required 0 0 %b %h",
               code_sync_status, bad_level, rx_even, cg_out, even_hold, cg_hold);
    end
    drive(1, 0, D162, 0, 0, 0);
  endtask

  task automatic test_saturate();
    drive(1, 0, D162, 0, 0, 1);
    n_checks++;
    if (loss_cnt !== 8'd0 || loss_cnt2 !== 2'd0) begin
      n_fail++;
      $display("FAIL sat_clr: loss=%0d loss2=%0d required 0 0", loss_cnt, loss_cnt2);
    end
    for (int e = 1; e <= 5; e++) begin
      sync_up();
      for (int b = 0; b < P_BAD; b++) drive(1, 1, D162, 1, 0, 0);
      n_checks++;
      if (loss_cnt !== 8'(e) || loss_cnt2 !== 2'((e < 3) ? e : 3)) begin
        n_fail++;
        $display("FAIL sat_evt%0d: loss=%0d loss2=%0d required %0d %0d", e, loss_cnt, loss_cnt2, e, (e < 3) ? e : 3);
      end
    end
    sync_up();
    for (int b = 0; b < P_BAD - 1; b++) drive(1, 1, D162, 1, 0, 0);
    drive(1, 1, D162, 1, 0, 1);
    n_checks++;
    if (loss_cnt !== 8'd0 || loss_cnt2 !== 2'd0 || code_sync_status !== 1'b0) begin
      n_fail++;
      $display("FAIL sat_clr_evt: loss=%0d loss2=%0d st=%b required 0 0 0", loss_cnt, loss_cnt2, code_sync_status);
    end
  endtask

  task automatic test_random();
    bit         ph = 0;
    bit         sd, en, inv, k, clr;
    logic [9:0] cg;
    for (int i = 0; i < 3000; i++) begin
      sd  = ($urandom_range(0, 99) >= 2);
      en  = ($urandom_range(0, 3) != 0);
      inv = ($urandom_range(0, 39) == 0);
      clr = ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 9) < 8) begin
        cg = ph ? D162 : (($urandom_range(0, 1) == 0) ? K285N : K285P);
        k  = !ph;
      end else begin
        cg = 10'($urandom);
        k  = $urandom_range(0, 1);
      end
      if (en) ph = !ph;
      drive(sd, en, cg, inv, k, clr);
      n_checks++;
      if (cg_out !== m_cg || comma_out !== m_comma || rx_even !== m_even ||
          code_sync_status !== (m_phase == 3) || bad_level !== 3'(m_level) ||
          loss_cnt !== 8'(m_loss) || loss_cnt2 !== 2'(m_loss2) ||
          code_sync_status2 !== (m_phase == 3) || bad_level2 !== 3'(m_level)) begin
        n_fail++;
        $display("FAIL random%0d: cg=%h comma=%b even=%b st=%b lvl=%0d loss=%0d loss2=%0d required %h %b %b %b %0d %0d %0d",
                 i, cg_out, comma_out, rx_even, code_sync_status, bad_level, loss_cnt, loss_cnt2,
                 m_cg, m_comma, m_even, (m_phase == 3), m_level, m_loss, m_loss2);
      end
    end
  endtask

  task automatic test_mid_reset();
    sync_up();
    #2;
    reset = 1'b0;
    #1;
    model_reset();
    n_checks++;
    if (code_sync_status !== 1'b0 || cg_out !== 10'd0 || rx_even !== 1'b0 || loss_cnt !== 8'd0) begin
      n_fail++;
      $display("FAIL midreset: st=%b cg=%h even=%b loss=%0d required 0 000 0 0", code_sync_status, cg_out, rx_even, loss_cnt);
    end
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    drive(1, 1, K285N, 0, 1, 0);
    n_checks++;
    if (rx_even !== 1'b1 || comma_out !== 1'b1 || code_sync_status !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset_first: even=%b comma=%b st=%b required 1 1 0", rx_even, comma_out, code_sync_status);
    end
  endtask

  initial begin
    test_reset();
    test_acquire();
    test_loss_bad();
    test_recover();
    test_acq_misaligned();
    test_signal_detect();
    test_saturate();
    test_random();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
